// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: consumes DIGIT bits of each operand per clock, LSB digit first,
// with valid/ready handshakes on both sides and carry-out / signed-overflow flags on the result.
module digit_serial_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = $clog2(NDIG) + 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
   logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [DIGIT:0]   dsum;
   logic             last_digit;

   assign dsum       = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
   assign last_digit = (cnt_q == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (in_valid)   state_d = S_RUN;
         S_RUN:   if (last_digit) state_d = S_DONE;
         S_DONE:  if (out_ready)  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
   end

   // Subtraction is folded into the add: b and the carry-in are inverted once at capture.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      cnt_d   = cnt_q;
      if (state_q == S_IDLE && in_valid) begin
         a_d     = a;
         b_d     = sub ? ~b : b;
         carry_d = sub ? ~cin : cin;
         a_msb_d = a[WIDTH-1];
         b_msb_d = sub ? ~b[WIDTH-1] : b[WIDTH-1];
         cnt_d   = '0;
      end else if (state_q == S_RUN) begin
         a_d     = a_q >> DIGIT;
         b_d     = b_q >> DIGIT;
         carry_d = dsum[DIGIT];
         sum_d   = (sum_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
         cnt_d   = cnt_q + CW'(1);
         if (last_digit) begin
            cout_d = dsum[DIGIT];
            ovf_d  = (a_msb_q == b_msb_q) && (dsum[DIGIT-1] != a_msb_q);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         cnt_q   <= cnt_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule
